audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 16, meaning the number of stereo entries (power of two, 4..256).
REQ-002 The block SHALL provide parameter AW, default 4, meaning log2(DEPTH).
REQ-003 The block SHALL provide parameter LOW_MARK, default 4, meaning the almost-empty threshold in entries.
REQ-004 The ports SHALL be:
- clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous reset, active-high.
- wr_left  in  1  strobe, latch wr_data as pending left sample.
- wr_right  in  1  strobe, push {left_hold, wr_data} as one stereo entry.
- wr_data  in  24  signed PCM sample from the bus side.
- clear_status  in  1  strobe, clear underrun_count and overflow.
- fifo_data  out  48  head entry, left in [47:24], right in [23:0].
- fifo_valid  out  1  head entry present.
- fifo_ready  in  1  consumer (I2S master) takes head this cycle.
- level  out  AW+1  stored entry count.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- low_irq  out  1  registered level <= LOW_MARK.
- overflow  out  1  sticky, push dropped while full.
- underrun_count  out  16  saturating count of ready-while-empty cycles.

Function
REQ-005 Storage SHALL be a DEPTH x 48 circular buffer with AW-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-006 wr_left alone SHALL load left_hold <= wr_data at the clock edge; left_hold retains its value otherwise.
REQ-007 wr_right alone SHALL push {left_hold, wr_data} when full == 0.
REQ-008 wr_left and wr_right in the same cycle SHALL push {wr_data, wr_data} (mono) and load left_hold <= wr_data.
REQ-009 A push attempted with full == 1 SHALL be dropped and SHALL set overflow, even when a pop occurs in the same cycle.
REQ-010 Outputs SHALL be show-ahead: fifo_valid = !empty and fifo_data = entry at the read pointer, both valid in the cycle after the push edge.
REQ-011 A pop SHALL occur on any edge where fifo_valid && fifo_ready; the read pointer then advances by one.
REQ-012 fifo_ready SHALL be treated as a single-cycle pulse; each cycle it is high with data present SHALL pop exactly one entry.
REQ-013 Level SHALL update as: push-only +1, pop-only -1, push and pop together unchanged; it SHALL never exceed DEPTH or go below 0.
REQ-014 full, empty and fifo_valid SHALL be decoded from the registered level with zero added latency.
REQ-015 fifo_ready high while empty SHALL increment underrun_count by 1, saturating at 16'hFFFF; fifo_data SHALL remain at its last value.
REQ-016 clear_status SHALL zero underrun_count and overflow, taking priority over a same-cycle increment or set.
REQ-017 low_irq SHALL be a register equal to (level <= LOW_MARK) sampled one cycle earlier, i.e. it lags level by one clock.
REQ-018 Memory contents SHALL NOT require reset; only pointers, level, flags, counters and left_hold are reset.

Reset
REQ-019 While rst is high the block SHALL set: pointers 0, level 0, empty 1, full 0, fifo_valid 0, left_hold 0, overflow 0, underrun_count 0, low_irq 1; all write and read strobes are ignored.
REQ-020 rst asserted mid-stream SHALL discard all stored entries within one clock, with no pop reported on that edge.

Verification
REQ-021 Write left=0x123456, right=0xABCDEF, hold fifo_ready low -> next cycle fifo_valid=1, fifo_data=48'h123456ABCDEF, level=1.
REQ-022 Push 16 pairs, then one more -> full=1, level=16, overflow=1, 17th entry absent; drain 16 ready pulses returns entries in order, then empty=1.
REQ-023 Three fifo_ready pulses with empty FIFO -> underrun_count=3; pulse clear_status concurrently with a fourth underrun -> count=0.
REQ-024 With level=16 apply wr_right and fifo_ready in the same cycle -> pop succeeds, push dropped, level=15, overflow=1.
REQ-025 Fill to 5 entries, pop one -> level=4 and low_irq=1 exactly one cycle later; wr_left+wr_right together with 0x000010 -> entry 48'h000010000010.
REQ-026 Push 20 and pop 20 interleaved across pointer wrap, then assert rst with 3 entries stored -> data order preserved across wrap; after rst level=0, fifo_valid=0.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// Stereo PCM sample FIFO between a bus-side writer and an I2S consumer.
// The writer supplies left then right samples; each right strobe pushes one
// 48-bit stereo entry. The head entry is visible without a read request, and
// the consumer pops it by asserting fifo_ready.
module audio_sample_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int LOW_MARK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_left,
  input  logic          wr_right,
  input  logic [23:0]   wr_data,
  input  logic          clear_status,
  output logic [47:0]   fifo_data,
  output logic          fifo_valid,
  input  logic          fifo_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          low_irq,
  output logic          overflow,
  output logic [15:0]   underrun_count
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW_L   = (AW+1)'(LOW_MARK);

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [23:0]   left_hold;
  // Last entry handed to the consumer; shown while the FIFO is empty so the
  // output does not drift onto stale storage after a drain.
  logic [47:0]   last_data;
  logic [47:0]   push_data;
  logic          push_ok;
  logic          pop;
  logic          underrun;

  // Flags decode straight from the registered level.
  assign empty      = (level_q == '0);
  assign full       = (level_q == DEPTH_L);
  assign fifo_valid = ~empty;
  assign level      = level_q;
  assign fifo_data  = empty ? last_data : mem[rd_ptr];

  // A simultaneous left+right strobe is a mono sample written to both halves.
  assign push_data = wr_left ? {wr_data, wr_data} : {left_hold, wr_data};
  assign push_ok   = wr_right & ~full;
  assign pop       = fifo_valid & fifo_ready;
  assign underrun  = fifo_ready & empty;

  // Sample storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, level and the held left sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      left_hold <= '0;
      last_data <= '0;
    end else begin
      if (wr_left) begin
        left_hold <= wr_data;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky status: overflow on a dropped push, saturating underrun count;
  // clear_status wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow       <= 1'b0;
      underrun_count <= '0;
    end else if (clear_status) begin
      overflow       <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (wr_right && full) begin
        overflow <= 1'b1;
      end
      if (underrun && underrun_count != 16'hFFFF) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  // Almost-empty interrupt, one clock behind the level it is derived from.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_irq <= 1'b1;
    end else begin
      low_irq <= (level_q <= LOW_L);
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_left;
  logic        wr_right;
  logic [23:0] wr_data;
  logic        clear_status;
  logic [47:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        low_irq;
  logic        overflow;
  logic [15:0] underrun_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  audio_sample_fifo #(.DEPTH(16), .AW(4), .LOW_MARK(4)) dut (
    .clk(clk), .rst(rst), .wr_left(wr_left), .wr_right(wr_right),
    .wr_data(wr_data), .clear_status(clear_status), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .level(level),
    .full(full), .empty(empty), .low_irq(low_irq), .overflow(overflow),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stereo entries plus status, updated per edge.
  logic [47:0] m_q[$];
  logic [23:0] m_hold;
  logic [47:0] m_last;
  logic        m_ovf;
  logic        m_low;
  int          m_und;

  always @(posedge clk) begin
    int          lvl;
    logic [47:0] pd;
    if (rst) begin
      m_q.delete();
      m_hold = '0;
      m_last = '0;
      m_ovf  = 1'b0;
      m_und  = 0;
      m_low  = 1'b1;
      chk_en = 1'b1;
    end else begin
      lvl = m_q.size();
      pd  = wr_left ? {wr_data, wr_data} : {m_hold, wr_data};
      if (fifo_ready && lvl > 0) m_last = m_q.pop_front();
      if (wr_right) begin
        if (lvl == 16) m_ovf = 1'b1;
        else m_q.push_back(pd);
      end
      if (wr_left) m_hold = wr_data;
      if (fifo_ready && lvl == 0 && m_und < 65535) m_und++;
      if (clear_status) begin
        m_und = 0;
        m_ovf = 1'b0;
      end
      m_low = (lvl <= 4);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", 64'(level), 64'(m_q.size()));
      check("valid", 64'(fifo_valid), 64'(m_q.size() > 0));
      check("empty", 64'(empty), 64'(m_q.size() == 0));
      check("full", 64'(full), 64'(m_q.size() == 16));
      check("data", 64'(fifo_data), 64'((m_q.size() > 0) ? m_q[0] : m_last));
      check("low_irq", 64'(low_irq), 64'(m_low));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underrun", 64'(underrun_count), 64'(m_und));
    end
  end

  task automatic drive(input logic wl, input logic wr, input logic [23:0] d,
                       input logic rdy, input logic clr);
    wr_left = wl; wr_right = wr; wr_data = d; fifo_ready = rdy; clear_status = clr;
    @(posedge clk); #1;
    wr_left = 1'b0; wr_right = 1'b0; fifo_ready = 1'b0; clear_status = 1'b0;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r, input logic rdy);
    drive(1'b1, 1'b0, l, 1'b0, 1'b0);
    drive(1'b0, 1'b1, r, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_left = 1'b0; wr_right = 1'b0; wr_data = '0;
    fifo_ready = 1'b0; clear_status = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_valid", 64'(fifo_valid), 64'd0);
    check("rst_low_irq", 64'(low_irq), 64'd1);

    // Basic stereo push, show-ahead head.
    push_pair(24'h123456, 24'hABCDEF, 1'b0);
    check("first_valid", 64'(fifo_valid), 64'd1);
    check("first_data", 64'(fifo_data), 64'h123456ABCDEF);
    check("first_level", 64'(level), 64'd1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("first_pop_empty", 64'(empty), 64'd1);

    // Fill to full, then one dropped push.
    for (int i = 0; i < 16; i++) push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i), 1'b0);
    push_pair(24'hDEAD00, 24'hBEEF00, 1'b0);
    check("full_flag", 64'(full), 64'd1);
    check("full_level", 64'(level), 64'd16);
    check("full_ovf", 64'(overflow), 64'd1);
    check("full_head", 64'(fifo_data), 64'h100000200000);

    // Push and pop while full: pop wins, push is dropped.
    drive(1'b0, 1'b1, 24'h777777, 1'b1, 1'b0);
    check("fullpp_level", 64'(level), 64'd15);
    check("fullpp_ovf", 64'(overflow), 64'd1);
    check("fullpp_head", 64'(fifo_data), 64'h100001200001);
    repeat (15) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(empty), 64'd1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Underruns, then clear beating a concurrent underrun.
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("underrun3", 64'(underrun_count), 64'd3);
    check("underrun_data_hold", 64'(fifo_data), 64'h10000F20000F);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("underrun_clr", 64'(underrun_count), 64'd0);

    // Low-mark interrupt lag.
    for (int i = 0; i < 5; i++) push_pair(24'h500000 + 24'(i), 24'h600000 + 24'(i), 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("lvl5", 64'(level), 64'd5);
    check("lvl5_low", 64'(low_irq), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("lvl4", 64'(level), 64'd4);
    check("lvl4_low_lag", 64'(low_irq), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("lvl4_low", 64'(low_irq), 64'd1);

    // Mono push updates both halves and the held left sample.
    drive(1'b1, 1'b1, 24'h000010, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 24'h000020, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("mono_entry", 64'(fifo_data), 64'h000010000010);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("after_mono", 64'(fifo_data), 64'h000010000020);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Interleaved traffic across pointer wrap, then reset mid-stream.
    for (int i = 0; i < 20; i++) push_pair(24'h300000 + 24'(i), 24'h400000 + 24'(i), i >= 2);
    check("wrap_level", 64'(level), 64'd2);
    check("wrap_head", 64'(fifo_data), 64'h300012400012);
    push_pair(24'h3000AA, 24'h4000AA, 1'b0);
    check("pre_rst_level", 64'(level), 64'd3);
    rst = 1'b1;
    drive(1'b0, 1'b1, 24'h999999, 1'b1, 1'b0);
    check("rst_mid_level", 64'(level), 64'd0);
    check("rst_mid_valid", 64'(fifo_valid), 64'd0);
    check("rst_mid_empty", 64'(empty), 64'd1);
    check("rst_mid_under", 64'(underrun_count), 64'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("post_rst_level", 64'(level), 64'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
